// File: rtl/pipelined_data_memory.sv
// pipelined_data_memory: fixed-latency, fully pipelined block memory behind the data cache.
// Accepts one request per cycle. Read responses come back in issue order and can be
// held off by resp_ready. After reset, a hardware sweep clears the array.
// Optional feature macro: DMEM_BYTE_MASK_EN adds the byte_mask port for per-byte writes.
`timescale 1ns/1ps
module pipelined_data_memory #(
  parameter int unsigned MEM_DEPTH  = 16384,
  parameter int unsigned DELAY      = 2,
  parameter int unsigned BLOCK_SIZE = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [BLOCK_SIZE*8-1:0] din,
`ifdef DMEM_BYTE_MASK_EN
  input  logic [BLOCK_SIZE-1:0]   byte_mask,
`endif
  input  logic                    resp_ready,
  output logic                    is_output_valid,
  output logic [BLOCK_SIZE*8-1:0] dout,
  output logic                    mem_ready
);
  localparam int unsigned DW   = BLOCK_SIZE * 8;
  localparam int unsigned AW   = $clog2(MEM_DEPTH);
  localparam int unsigned LAST = DELAY - 1;

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_e;

  logic [DW-1:0]         mem [MEM_DEPTH];
  state_e                state_q, state_d;
  logic [AW-1:0]         ptr_q, ptr_d;
  logic [DELAY-1:0]      vld_q, vld_d;
  logic                  rd_q   [DELAY];
  logic [AW-1:0]         idx_q  [DELAY];
  logic [DW-1:0]         din_q  [DELAY];
  logic [BLOCK_SIZE-1:0] mask_q [DELAY];
  logic                  out_vld_q, out_vld_d;
  logic [DW-1:0]         out_data_q, out_data_d;
  logic                  stall_c, advance_c, accept_c, rd_done_c, wr_done_c;
  logic [BLOCK_SIZE-1:0] req_mask_c;
  logic                  unused_addr_c;

`ifdef DMEM_BYTE_MASK_EN
  assign req_mask_c = byte_mask;
`else
  assign req_mask_c = '1;
`endif

  // Upper block-index bits are ignored by design
  assign unused_addr_c = ^addr[31:AW];

  // Pipeline moves only in RUN and when the held response is not blocked
  assign stall_c   = out_vld_q & ~resp_ready;
  assign advance_c = (state_q == S_RUN) & ~stall_c;
  assign accept_c  = is_input_valid & (mem_read | mem_write) & advance_c;
  assign rd_done_c = advance_c & vld_q[LAST] & rd_q[LAST];
  assign wr_done_c = advance_c & vld_q[LAST] & ~rd_q[LAST];
  assign mem_ready = advance_c;

  assign is_output_valid = out_vld_q;
  assign dout            = out_data_q;

  // Control state, clear pointer, stage valids and response registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_INIT;
      ptr_q      <= '0;
      vld_q      <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      vld_q      <= vld_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end

  // Next state: clear sweep walks every block once, then RUN
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == S_INIT) begin
      ptr_d = ptr_q + AW'(1);
      if (ptr_q == AW'(MEM_DEPTH - 1)) begin
        state_d = S_RUN;
        ptr_d   = '0;
      end
    end
  end

  // Stage valids shift on advance; a bubble enters when nothing is accepted
  always_comb begin
    vld_d = vld_q;
    if (advance_c) begin
      vld_d[0] = accept_c;
      for (int unsigned i = 1; i < DELAY; i++) vld_d[i] = vld_q[i-1];
    end
  end

  // Response: load on read completion, clear when consumed with nothing new
  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    if (advance_c) begin
      out_vld_d  = rd_done_c;
      out_data_d = rd_done_c ? mem[idx_q[LAST]] : '0;
    end
  end

  // Stage payloads; qualified by the valids, so no reset needed
  always_ff @(posedge clk) begin
    if (advance_c) begin
      rd_q[0]   <= mem_read & ~mem_write;
      idx_q[0]  <= addr[AW-1:0];
      din_q[0]  <= din;
      mask_q[0] <= req_mask_c;
      for (int unsigned i = 1; i < DELAY; i++) begin
        rd_q[i]   <= rd_q[i-1];
        idx_q[i]  <= idx_q[i-1];
        din_q[i]  <= din_q[i-1];
        mask_q[i] <= mask_q[i-1];
      end
    end
  end

  // Array: sweep clear during INIT, byte-enabled write on write completion
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      mem[ptr_q] <= '0;
    end else if (wr_done_c) begin
      for (int unsigned b = 0; b < BLOCK_SIZE; b++) begin
        if (mask_q[LAST][b]) mem[idx_q[LAST]][b*8 +: 8] <= din_q[LAST][b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_data_memory.sv
// Self-checking bench for pipelined_data_memory (MEM_DEPTH=16, DELAY=2, BLOCK_SIZE=16).
// Reference model: array updated in issue order plus a queue of expected read data.
`timescale 1ns/1ps
module tb_pipelined_data_memory;
  localparam logic [127:0] A5 = {16{8'hA5}};
  localparam logic [127:0] C3 = {16{8'hC3}};

  logic         clk;
  logic         reset_n;
  logic         is_input_valid;
  logic [31:0]  addr;
  logic         mem_read;
  logic         mem_write;
  logic [127:0] din;
`ifdef DMEM_BYTE_MASK_EN
  logic [15:0]  byte_mask;
`endif
  logic         resp_ready;
  logic         is_output_valid;
  logic [127:0] dout;
  logic         mem_ready;

  pipelined_data_memory #(.MEM_DEPTH(16), .DELAY(2), .BLOCK_SIZE(16)) dut (
    .clk(clk), .reset_n(reset_n), .is_input_valid(is_input_valid), .addr(addr),
    .mem_read(mem_read), .mem_write(mem_write), .din(din),
`ifdef DMEM_BYTE_MASK_EN
    .byte_mask(byte_mask),
`endif
    .resp_ready(resp_ready), .is_output_valid(is_output_valid), .dout(dout),
    .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_chk = 0;
  int           n_err = 0;
  logic [127:0] ref_mem [16];
  logic [127:0] exp_q [$];
  logic         out_v;
  logic [127:0] out_d;
  logic         rdy_s;
  logic         run_chk = 1'b0;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [3:0]   idx;
    logic [127:0] d;
    logic         ev;
    logic [127:0] ed;
  } vec_t;
  vec_t tbl [12];

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // One clock cycle: sample outputs, drive inputs, update model on acceptance
  task automatic cycle(input logic v, input logic rd, input logic wr, input logic [3:0] idx,
                       input logic [127:0] d, input logic [15:0] m, input logic rr);
    logic [15:0] me;
    @(negedge clk);
    out_v = is_output_valid;
    out_d = dout;
    if (!out_v) begin
      chk("idle_dout_zero", out_d, 128'd0);
    end else if (rr) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL spurious_resp: got response %h expected none", out_d);
      end else begin
        chk("resp_data", out_d, exp_q.pop_front());
      end
    end
    is_input_valid = v;
    mem_read       = rd;
    mem_write      = wr;
    addr           = {$urandom_range(0, 15), 24'd0, 4'(idx)};
    din            = d;
    resp_ready     = rr;
`ifdef DMEM_BYTE_MASK_EN
    byte_mask = m;
    me        = m;
`else
    me        = 16'hFFFF;
`endif
    #1;
    rdy_s = mem_ready;
    if (run_chk) chk("mem_ready_rule", 128'(rdy_s), 128'(!(out_v && !rr)));
    if (rdy_s && v && (rd || wr)) begin
      if (wr) begin
        for (int b = 0; b < 16; b++) if (me[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
      end else begin
        exp_q.push_back(ref_mem[idx]);
      end
    end
  endtask

  task automatic idle(input logic rr);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 128'd0, 16'hFFFF, rr);
  endtask

  task automatic do_reset();
    int cnt;
    @(negedge clk);
    is_input_valid = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    resp_ready     = 1'b1;
    reset_n        = 1'b0;
    #1;
    chk("rst_valid", 128'(is_output_valid), 128'd0);
    chk("rst_dout", dout, 128'd0);
    chk("rst_ready", 128'(mem_ready), 128'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (mem_ready) break;
      cnt++;
      @(negedge clk);
    end
    chk("init_cycles", 128'(cnt), 128'd16);
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    exp_q.delete();
    run_chk = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1'b1);
    repeat (3) idle(1'b1);
    chk("drain_empty", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    addr = '0; din = '0; resp_ready = 1'b1;
`ifdef DMEM_BYTE_MASK_EN
    byte_mask = '0;
`endif
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;

    // rows: inputs for the cycle, expected outputs sampled before that cycle's drive
    tbl[0]  = '{1'b0, 1'b1, 4'd3, A5,     1'b0, 128'd0};
    tbl[1]  = '{1'b0, 1'b1, 4'd1, C3,     1'b0, 128'd0};
    tbl[2]  = '{1'b1, 1'b0, 4'd3, 128'd0, 1'b0, 128'd0};
    tbl[3]  = '{1'b1, 1'b0, 4'd0, 128'd0, 1'b0, 128'd0};
    tbl[4]  = '{1'b1, 1'b0, 4'd1, 128'd0, 1'b0, 128'd0};
    tbl[5]  = '{1'b1, 1'b0, 4'd2, 128'd0, 1'b1, A5};
    tbl[6]  = '{1'b1, 1'b0, 4'd3, 128'd0, 1'b1, 128'd0};
    tbl[7]  = '{1'b1, 1'b0, 4'd5, 128'd0, 1'b1, C3};
    tbl[8]  = '{1'b0, 1'b0, 4'd0, 128'd0, 1'b1, 128'd0};
    tbl[9]  = '{1'b0, 1'b0, 4'd0, 128'd0, 1'b1, A5};
    tbl[10] = '{1'b0, 1'b0, 4'd0, 128'd0, 1'b1, 128'd0};
    tbl[11] = '{1'b0, 1'b0, 4'd0, 128'd0, 1'b0, 128'd0};

    // Reset and clear sweep timing
    do_reset();

    // Write-then-read latency and back-to-back in-order reads
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].rd | tbl[i].wr, tbl[i].rd, tbl[i].wr, tbl[i].idx, tbl[i].d, 16'hFFFF, 1'b1);
      chk($sformatf("tbl%0d_valid", i), 128'(out_v), 128'(tbl[i].ev));
      chk($sformatf("tbl%0d_dout", i), out_d, tbl[i].ed);
      chk($sformatf("tbl%0d_ready", i), 128'(rdy_s), 128'd1);
    end

    // Back-pressure: hold response 3 cycles while a new request is refused
    cycle(1'b1, 1'b1, 1'b0, 4'd3, 128'd0, 16'hFFFF, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 4'd1, 128'd0, 16'hFFFF, 1'b1);
    idle(1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 4'd0, 128'd0, 16'hFFFF, 1'b0);
      chk($sformatf("stall%0d_valid", i), 128'(out_v), 128'd1);
      chk($sformatf("stall%0d_dout", i), out_d, A5);
      chk($sformatf("stall%0d_ready", i), 128'(rdy_s), 128'd0);
    end
    idle(1'b1);
    chk("release_first", out_d, A5);
    idle(1'b1);
    chk("release_second_valid", 128'(out_v), 128'd1);
    chk("release_second", out_d, C3);
    idle(1'b1);
    chk("release_done", 128'(out_v), 128'd0);
    drain();

    // Randomized traffic with random back-pressure against the model
    for (int i = 0; i < 400; i++) begin
      int op;
      op = $urandom_range(0, 3);
      cycle($urandom_range(0, 3) != 0, op[0], op[1], 4'($urandom_range(0, 15)),
            {$urandom, $urandom, $urandom, $urandom}, 16'($urandom),
            $urandom_range(0, 3) != 0);
    end
    drain();

    // Reset with two writes in flight: neither may land
    cycle(1'b1, 1'b0, 1'b1, 4'd9,  A5, 16'hFFFF, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 4'd10, C3, 16'hFFFF, 1'b1);
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 4'd9,  128'd0, 16'hFFFF, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 4'd10, 128'd0, 16'hFFFF, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("rst_inflight_idx9_valid", 128'(out_v), 128'd1);
    chk("rst_inflight_idx9", out_d, 128'd0);
    idle(1'b1);
    chk("rst_inflight_idx10", out_d, 128'd0);
    drain();

`ifdef DMEM_BYTE_MASK_EN
    // Partial write: only byte 0 cleared
    cycle(1'b1, 1'b0, 1'b1, 4'd7, {16{8'hFF}}, 16'hFFFF, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 4'd7, 128'd0,      16'h0001, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 4'd7, 128'd0,      16'hFFFF, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("mask_valid", 128'(out_v), 128'd1);
    chk("mask_data", out_d, {{15{8'hFF}}, 8'h00});
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
